// File: rtl/param_waveform_generator.sv
// -----------------------------------------------------------------------------
// param_waveform_generator
//
// Phase-accumulator waveform source. It produces saw, square, triangle,
// parabolic sine, and full-wave / half-wave rectified sine. The selected
// waveform is scaled by an amplitude register. Configuration is taken through
// a valid/ready handshake into shadow registers. The shadow is committed to
// the active registers only at a phase wrap, a phase_sync, or while the
// accumulator is stopped, so waveform switches never glitch mid-period.
//
// Parameters:
//   WIDTH   - output sample width / phase-to-amplitude resolution (4..16)
//   PHASE_W - phase accumulator width (>= WIDTH)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           advance the accumulator by the active tuning word
//   phase_sync   force phase to 0 on the next edge (priority over en)
//   cfg_valid    configuration offer
//   cfg_ready    block can accept a configuration (IDLE)
//   cfg_ftw      frequency tuning word
//   cfg_mode     0 saw, 1 square, 2 triangle, 3 sine, 4 full-wave,
//                5 half-wave, 6-7 off
//   cfg_duty     square-wave threshold
//   cfg_amp      amplitude (all ones = unity gain)
//   wave_out     registered output sample
//   wrap         one-cycle pulse on phase wrap or phase_sync
//   active_mode  currently committed mode
// -----------------------------------------------------------------------------
module param_waveform_generator #(
    parameter int WIDTH   = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_sync,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [2:0]         cfg_mode,
    input  logic [WIDTH-1:0]   cfg_duty,
    input  logic [WIDTH-1:0]   cfg_amp,
    output logic [WIDTH-1:0]   wave_out,
    output logic               wrap,
    output logic [2:0]         active_mode
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } cfg_state_t;

    localparam logic [2:0] MODE_SAW    = 3'd0;
    localparam logic [2:0] MODE_SQUARE = 3'd1;
    localparam logic [2:0] MODE_TRI    = 3'd2;
    localparam logic [2:0] MODE_SINE   = 3'd3;
    localparam logic [2:0] MODE_FULL   = 3'd4;
    localparam logic [2:0] MODE_HALF   = 3'd5;

    localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] HALF_M1 = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FULL    = {WIDTH{1'b1}};

    // ---------------------------------------------------------------- state
    logic [PHASE_W-1:0] phase_reg;
    logic               wrap_reg;
    cfg_state_t         state_reg;
    logic               cfg_ready_reg;

    logic [PHASE_W-1:0] shadow_ftw_reg;
    logic [2:0]         shadow_mode_reg;
    logic [WIDTH-1:0]   shadow_duty_reg;
    logic [WIDTH-1:0]   shadow_amp_reg;

    logic [PHASE_W-1:0] ftw_reg;
    logic [2:0]         mode_reg;
    logic [WIDTH-1:0]   duty_reg;
    logic [WIDTH-1:0]   amp_reg;

    logic [WIDTH-1:0]   wave_reg;

    // ---------------------------------------------------------- accumulator
    logic [PHASE_W:0] phase_sum;
    logic             carry;
    logic             commit;

    assign phase_sum = {1'b0, phase_reg} + {1'b0, ftw_reg};
    assign carry     = phase_sum[PHASE_W];
    // Commit when the period boundary is reached, or when the accumulator is
    // not running (nothing to glitch). The carry term only matters with en=1;
    // with en=0 the ~en term already fires.
    assign commit    = phase_sync | ~en | carry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else if (phase_sync) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b1;
        end else if (en) begin
            phase_reg <= phase_sum[PHASE_W-1:0];
            wrap_reg  <= carry;
        end else begin
            wrap_reg  <= 1'b0;
        end
    end

    // ------------------------------------------------------- config FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cfg_ready_reg   <= 1'b1;
            shadow_ftw_reg  <= '0;
            shadow_mode_reg <= '0;
            shadow_duty_reg <= HALF;
            shadow_amp_reg  <= FULL;
            ftw_reg         <= '0;
            mode_reg        <= MODE_SAW;
            duty_reg        <= HALF;
            amp_reg         <= FULL;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        shadow_ftw_reg  <= cfg_ftw;
                        shadow_mode_reg <= cfg_mode;
                        shadow_duty_reg <= cfg_duty;
                        shadow_amp_reg  <= cfg_amp;
                        state_reg       <= ST_PEND;
                        cfg_ready_reg   <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (commit) begin
                        ftw_reg       <= shadow_ftw_reg;
                        mode_reg      <= shadow_mode_reg;
                        duty_reg      <= shadow_duty_reg;
                        amp_reg       <= shadow_amp_reg;
                        state_reg     <= ST_IDLE;
                        cfg_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cfg_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // --------------------------------------------------- sample derivation
    logic [WIDTH-1:0]   p;
    logic [WIDTH-2:0]   h;
    logic [WIDTH-1:0]   m_minus_h;
    logic [2*WIDTH-1:0] sine_prod;
    logic [2*WIDTH-1:0] sine_shr;
    logic [WIDTH-1:0]   sine_s;
    logic [WIDTH-1:0]   sine_val;
    logic [WIDTH:0]     two_s;
    logic [WIDTH-1:0]   rect_val;
    logic [WIDTH-1:0]   p_dbl;
    logic [WIDTH-1:0]   sel;
    logic [WIDTH:0]     amp_plus;
    logic [2*WIDTH:0]   scaled;
    logic               unused_scaled;

    assign p         = phase_reg[PHASE_W-1 -: WIDTH];
    assign h         = p[WIDTH-2:0];
    assign m_minus_h = HALF - {1'b0, h};

    // Parabola h*(M-h) peaks at M^2/4; shifting by WIDTH-3 maps the peak to M,
    // which is then clipped to M-1 so the positive half fits above midscale.
    assign sine_prod = {{(WIDTH+1){1'b0}}, h} * {{WIDTH{1'b0}}, m_minus_h};
    assign sine_shr  = sine_prod >> (WIDTH-3);
    assign sine_s    = (sine_shr > {{WIDTH{1'b0}}, HALF_M1}) ? HALF_M1
                                                              : sine_shr[WIDTH-1:0];
    assign sine_val  = p[WIDTH-1] ? (HALF_M1 - sine_s) : (HALF + sine_s);

    assign two_s     = {sine_s, 1'b0};
    assign rect_val  = (two_s > {1'b0, FULL}) ? FULL : two_s[WIDTH-1:0];

    // p<<1 truncated to WIDTH bits; the falling half is its bitwise inverse.
    assign p_dbl     = {p[WIDTH-2:0], 1'b0};

    always_comb begin
        sel = '0;
        case (mode_reg)
            MODE_SAW:    sel = p;
            MODE_SQUARE: sel = (p < duty_reg) ? FULL : '0;
            MODE_TRI:    sel = p[WIDTH-1] ? ~p_dbl : p_dbl;
            MODE_SINE:   sel = sine_val;
            MODE_FULL:   sel = rect_val;
            MODE_HALF:   sel = p[WIDTH-1] ? '0 : rect_val;
            default:     sel = '0;
        endcase
    end

    // Multiplying by amp+1 makes amp = all ones an exact unity gain after
    // the >>WIDTH. The top product bit is always zero for in-range operands.
    assign amp_plus      = {1'b0, amp_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign scaled        = {{(WIDTH+1){1'b0}}, sel} * {{WIDTH{1'b0}}, amp_plus};
    assign unused_scaled = ^{scaled[2*WIDTH], scaled[WIDTH-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wave_reg <= '0;
        end else begin
            wave_reg <= scaled[2*WIDTH-1:WIDTH];
        end
    end

    // -------------------------------------------------------------- outputs
    assign wave_out    = wave_reg;
    assign wrap        = wrap_reg;
    assign cfg_ready   = cfg_ready_reg;
    assign active_mode = mode_reg;

endmodule

// File: doc/param_waveform_generator.md
Name: param_waveform_generator

Overview:
- Parametrised, self-clocked successor to the fixed 8-bit waveform processor.
- An internal phase accumulator replaces the externally driven count. A single WIDTH-bit output carries the waveform chosen by a mode register, scaled by an amplitude register.
- Configuration arrives through a valid/ready handshake. It is shadowed and committed only at a phase wrap, so mode or frequency changes are glitch-free.
- Feeds the DAC/display path of the lab waveform subsystem.

Parameters:
- WIDTH, 8: output sample width and phase-to-amplitude resolution; legal range 4..16.
- PHASE_W, 16: phase accumulator width; must be >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  advances the accumulator when 1.
- phase_sync  input  1  forces phase to 0 on the next edge.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  block can accept config.
- cfg_ftw  input  PHASE_W  frequency tuning word.
- cfg_mode  input  3  0 saw, 1 square, 2 triangle, 3 sine, 4 full-wave rectified, 5 half-wave rectified, 6-7 off (output 0).
- cfg_duty  input  WIDTH  square threshold.
- cfg_amp  input  WIDTH  amplitude.
- wave_out  output  WIDTH  registered sample.
- wrap  output  1  one-cycle pulse on phase wrap.
- active_mode  output  3  currently committed mode.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - phase=0; pending=0; cfg_ready=1; wave_out=0; wrap=0.
  - Active config: ftw=0, mode=0, duty=2^(WIDTH-1), amp=all ones.
- Accumulator:
  - With en=1: phase <= phase + ftw (mod 2^PHASE_W). wrap <= carry-out of that sum.
  - With en=0: phase holds and wrap <= 0.
  - phase_sync=1 has priority over en: phase <= 0 and wrap <= 1.
- Sample derivation:
  - p = phase[PHASE_W-1 -: WIDTH]; M = 2^(WIDTH-1); MAX = 2^WIDTH-1.
  - saw = p.
  - square = (p < duty) ? MAX : 0.
  - triangle = p[WIDTH-1] ? ~(p<<1) : (p<<1), truncated to WIDTH bits.
  - sine uses parabolic segments. h = p[WIDTH-2:0]; s = min((h*(M-h)) >> (WIDTH-3), M-1).
    - Sine = p[WIDTH-1]==0 ? M+s : M-1-s.
  - full-wave = min(2s, MAX).
  - half-wave = p[WIDTH-1]==0 ? min(2s, MAX) : 0.
  - Scaling: wave_out <= (sel * (amp+1)) >> WIDTH. Intermediate product is 2*WIDTH+1 bits; amp=all-ones gives unity.
- Latency: wave_out at edge t+1 = f(phase, active config) as registered before edge t+1, i.e. one cycle behind phase.
- wave_out updates every cycle, including when en=0; it holds its value only because phase holds.
- Config FSM, two states:
  - IDLE (cfg_ready=1): cfg_valid=1 captures cfg_* into the shadow registers and moves to PEND.
  - PEND (cfg_ready=0): ignores cfg_valid. Commits shadow to active and returns to IDLE on the first edge where any of these holds: the accumulator carry occurs; phase_sync=1; en=0.
  - The committed config takes effect on the sample computed in the following cycle.
- Capture and commit never happen on the same edge: a config offered in IDLE while en=0 commits on the next edge.
- ftw=0 with en=1: phase is frozen, so a pending config waits indefinitely until phase_sync or en=0. This is the intended behaviour.
- active_mode reflects the active register.
- Reset mid-PEND discards the shadow.
- Mode 6-7 outputs 0 but the accumulator keeps running.

Test Plan:
- Reset then defaults: rst low 2 cycles, release → wave_out=0, cfg_ready=1, active_mode=0.
- Saw ramp (WIDTH=8, PHASE_W=16):
  - Stimulus: en=0; load ftw=0x0100, mode=0. Then en=1 for 300 cycles.
  - Required: wave_out 0,1,2…255,0; wrap pulses once every 256 cycles, coincident with phase returning to 0.
- Sine points at ftw=0x0100:
  - p=0 → 128; p=64 → 255; p=128 → 127; p=192 → 0.
  - With amp=0x7F: p=64 → 127.
- Deferred switch:
  - Running saw at p=100, offer mode=1, duty=0x40.
  - cfg_ready drops next cycle; wave_out keeps ramping to 255.
  - After wrap, the square wave shows 255 for p<64 and 0 for p≥64; cfg_ready returns to 1.
- phase_sync mid-cycle with a pending config: next edge phase=0, wrap=1, active_mode updated. Following edge wave_out = new waveform at p=0.
- Async reset mid-PEND: rst asserted between clock edges → outputs clear immediately; the shadowed config is never applied.
